// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the CPU memory stage and a byte-addressed data memory port.
// Aligned requests issue one access; misaligned halfword/word requests are split into byte beats or trapped.
module lsu_mem_initiator #(
  parameter bit MISALIGN_TRAP = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic        req_store,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_extend_sign,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        store_q, store_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic        req_aligned;
  logic        last_beat;
  logic [3:0]  beat_onehot;
  logic [31:0] asm_merged;
  logic [31:0] split_result;
  logic [7:0]  beat_wbyte;

  assign req_aligned = (req_size == 2'b00)
                    || (req_size == 2'b01 && !req_addr[0])
                    || (req_size[1] && req_addr[1:0] == 2'b00);

  // A misaligned request is either a halfword (2 beats) or a word (4 beats).
  assign last_beat = (size_q == 2'b01) ? (beat_q == 2'd1) : (beat_q == 2'd3);

  // Byte lane gi of the assembled load takes the memory byte on its own beat.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign beat_onehot[gi]       = (beat_q == 2'(gi));
    assign asm_merged[8*gi +: 8] = beat_onehot[gi] ? mem_rdata[7:0] : asm_q[8*gi +: 8];
  end

  always_comb begin
    beat_wbyte = wdata_q[7:0];
    case (beat_q)
      2'd1:    beat_wbyte = wdata_q[15:8];
      2'd2:    beat_wbyte = wdata_q[23:16];
      2'd3:    beat_wbyte = wdata_q[31:24];
      default: beat_wbyte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    split_result = asm_merged;
    if (size_q == 2'b01) begin
      split_result = {{16{sign_q & asm_merged[15]}}, asm_merged[15:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    store_d = store_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          sign_d  = req_sign;
          store_d = req_store;
          wdata_d = req_wdata;
          beat_d  = 2'd0;
          asm_d   = 32'd0;
          if (req_aligned) begin
            state_d = ACCESS;
          end else if (MISALIGN_TRAP) begin
            state_d = RESP;
            rdata_d = 32'd0;
            mis_d   = 1'b1;
          end else begin
            state_d = SPLIT;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = store_q ? 32'd0 : mem_rdata;
        mis_d   = 1'b0;
      end
      SPLIT: begin
        asm_d  = asm_merged;
        beat_d = beat_q + 2'd1;
        if (last_beat) begin
          state_d = RESP;
          rdata_d = store_q ? 32'd0 : split_result;
          mis_d   = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The memory and register file also update on the falling edge.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= 32'd0;
      beat_q  <= 2'd0;
      asm_q   <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == RESP);
    resp_rdata      = rdata_q;
    resp_misaligned = mis_q;
    mem_addr        = 32'd0;
    mem_size        = 2'b10;
    mem_extend_sign = 1'b0;
    mem_wdata       = 32'd0;
    mem_wen         = 1'b1;
    case (state_q)
      ACCESS: begin
        mem_addr        = addr_q;
        mem_size        = size_q;
        mem_extend_sign = sign_q;
        mem_wdata       = wdata_q;
        mem_wen         = ~store_q;
      end
      SPLIT: begin
        mem_addr        = addr_q + {30'd0, beat_q};
        mem_size        = 2'b00;
        mem_extend_sign = 1'b0;
        mem_wdata       = {24'd0, beat_wbyte};
        mem_wen         = ~store_q;
      end
      default: begin
        mem_wen = 1'b1;
      end
    endcase
  end

endmodule
